// File: rtl/rns_reverse_converter_seq_if.sv
// Handshake and data bundle for the sequential RNS reverse converter.
// The err signal exists only when RNS_RANGE_CHECK_EN is defined.
interface rns_reverse_converter_seq_if #(
    parameter int N = 4
);
    logic             start;
    logic [N-1:0]     residue_a;
    logic [N-1:0]     residue_b;
    logic [N:0]       residue_c;
    logic             busy;
    logic             done;
    logic [3*N-1:0]   result;
`ifdef RNS_RANGE_CHECK_EN
    logic             err;
`endif

    // Handshake: start is a request pulse honoured only while busy is low
    // (done cycle included); busy covers the whole conversion; done is a
    // one-cycle pulse in which result (and err) are valid; result holds
    // until the next done.
    modport master (
        output start, residue_a, residue_b, residue_c,
`ifdef RNS_RANGE_CHECK_EN
        input  err,
`endif
        input  busy, done, result
    );

    modport slave (
        input  start, residue_a, residue_b, residue_c,
`ifdef RNS_RANGE_CHECK_EN
        output err,
`endif
        output busy, done, result
    );
endinterface

// File: rtl/rns_reverse_converter_seq.sv
// Sequential residue-to-binary converter for moduli {2^N, 2^N-1, 2^N+1}
// using mixed-radix conversion. Optional macro RNS_RANGE_CHECK_EN adds the
// err output, flagging residue_c > 2^N at acceptance.
module rns_reverse_converter_seq #(
    parameter int N = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    rns_reverse_converter_seq_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_V2       = 3'd1;
    localparam logic [2:0] S_V3       = 3'd2;
    localparam logic [2:0] S_SCALE    = 3'd3;
    localparam logic [2:0] S_RECON_HI = 3'd4;
    localparam logic [2:0] S_RECON    = 3'd5;

    localparam int              CW       = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 2);
    localparam logic [N+2:0]    M2_W     = (N+3)'((1 << N) - 1);
    localparam logic [N+2:0]    M3_W     = (N+3)'((1 << N) + 1);
    localparam logic [N+1:0]    M3_S     = (N+2)'((1 << N) + 1);
`ifdef RNS_RANGE_CHECK_EN
    localparam logic [N:0]      C_MAX    = (N+1)'(1 << N);
`endif

    logic [2:0]       state_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [N:0]       c_q;
    logic [N-1:0]     v2_q;
    logic [N:0]       s_q;
    logic [CW-1:0]    cnt_q;
    logic [2*N-1:0]   inner_q;
    logic             busy_q;
    logic             done_q;
    logic [3*N-1:0]   result_q;
`ifdef RNS_RANGE_CHECK_EN
    logic             oor_q;
    logic             err_q;
`endif

    // Arithmetic is carried in N+3 bits so the sign bit of each subtraction
    // is visible even for an out-of-range residue_c.
    logic [N+2:0]     d2_raw;
    logic [N+2:0]     d2_mod;
    logic [N-1:0]     v2_calc;
    logic [N+2:0]     t1_raw;
    logic [N+2:0]     t1_mod;
    logic [N+2:0]     t2_raw;
    logic [N+2:0]     t2_mod;
    logic [N+1:0]     s_dbl;
    logic [N+1:0]     s_red;
    logic [2*N:0]     inner_calc;
    logic             unused_bits;

    // Per-step modular arithmetic: v2, t, one doubling step, and v2+(2^N-1)*v3.
    always_comb begin
        d2_raw     = {3'b000, b_q} - {3'b000, a_q};
        d2_mod     = d2_raw[N+2] ? d2_raw + M2_W : d2_raw;
        // b = 2^N-1 is a second encoding of zero; fold it here.
        v2_calc    = (d2_mod == M2_W) ? '0 : d2_mod[N-1:0];
        t1_raw     = {3'b000, a_q} - {2'b00, c_q};
        t1_mod     = t1_raw[N+2] ? t1_raw + M3_W : t1_raw;
        t2_raw     = t1_mod - {3'b000, v2_q};
        t2_mod     = t2_raw[N+2] ? t2_raw + M3_W : t2_raw;
        s_dbl      = {s_q, 1'b0};
        s_red      = (s_dbl >= M3_S) ? s_dbl - M3_S : s_dbl;
        // (2^N-1)*v3 as (v3 << N) - v3; the sum never exceeds 2^(2N)-2.
        inner_calc = {s_q, {N{1'b0}}} - {{N{1'b0}}, s_q} + {{(N+1){1'b0}}, v2_q};
    end

    // Bits provably zero for legal inputs.
    assign unused_bits = ^{t2_mod[N+2:N+1], s_red[N+1], inner_calc[2*N]};

    // Conversion FSM: IDLE -> V2 -> V3 -> SCALE (N-1 cycles) -> RECON_HI -> RECON.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            v2_q     <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            inner_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef RNS_RANGE_CHECK_EN
            oor_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef RNS_RANGE_CHECK_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.residue_a;
                        b_q     <= bus.residue_b;
                        c_q     <= bus.residue_c;
`ifdef RNS_RANGE_CHECK_EN
                        oor_q   <= (bus.residue_c > C_MAX);
`endif
                        busy_q  <= 1'b1;
                        state_q <= S_V2;
                    end
                end
                S_V2: begin
                    v2_q    <= v2_calc;
                    state_q <= S_V3;
                end
                S_V3: begin
                    s_q     <= t2_mod[N:0];
                    cnt_q   <= '0;
                    state_q <= S_SCALE;
                end
                S_SCALE: begin
                    // N-1 modular doublings multiply t by 2^(N-1).
                    s_q   <= s_red[N:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_RECON_HI;
                    end
                end
                S_RECON_HI: begin
                    inner_q <= inner_calc[2*N-1:0];
                    state_q <= S_RECON;
                end
                S_RECON: begin
                    // Adding v1 < 2^N to inner*2^N is a plain concatenation.
                    result_q <= {inner_q, a_q};
`ifdef RNS_RANGE_CHECK_EN
                    if (oor_q) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
`endif
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
`ifdef RNS_RANGE_CHECK_EN
    assign bus.err    = err_q;
`endif
endmodule

// File: tb/tb_rns_reverse_converter_seq.sv
// Self-checking bench for rns_reverse_converter_seq (N=4), with a CRT
// search model as reference. Covers RNS_RANGE_CHECK_EN when defined.
module tb_rns_reverse_converter_seq;
    localparam int N      = 4;
    localparam int M1     = 1 << N;
    localparam int M2     = M1 - 1;
    localparam int M3     = M1 + 1;
    localparam int P      = M1 * M2 * M3;
    localparam int LAT    = N + 3;
    localparam int BUDGET = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rns_reverse_converter_seq_if #(.N(N)) bus ();

    rns_reverse_converter_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec      = 0;
    int n_err      = 0;
    int done_total = 0;
    logic [3*N-1:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    // Counts every done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_total++;
    end

    // Reference: the unique X in [0,P) congruent to the residues (CRT search).
    function automatic int ref_x(input int a, input int b, input int c);
        for (int x = 0; x < P; x++) begin
            if ((x % M1) == a && (x % M2) == (b % M2) && (x % M3) == c) return x;
        end
        return -1;
    endfunction

    // Drives one start pulse from a negedge; returns at the negedge after acceptance.
    task automatic launch(input int a, input int b, input int c);
        bus.start     = 1'b1;
        bus.residue_a = N'(a);
        bus.residue_b = N'(b);
        bus.residue_c = (N+1)'(c);
        @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.residue_a = N'($urandom_range(0, M1 - 1));
        bus.residue_b = N'($urandom_range(0, M1 - 1));
        bus.residue_c = (N+1)'($urandom_range(0, 2 * M1 - 1));
    endtask

    // Waits (bounded) for done; k counts edges since the accepting edge.
    task automatic wait_done(input int k0, output logic [3*N-1:0] res, output int k,
                             output int busy_cnt);
        k = k0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && k < BUDGET) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            k++;
        end
        res = bus.result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.residue_a = '0;
        bus.residue_b = '0;
        bus.residue_c = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_vec++;
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_vec++;
        if (bus.result !== '0) begin n_err++; $display("FAIL reset_result got=%0d exp=0", bus.result); end
`ifdef RNS_RANGE_CHECK_EN
        n_vec++;
        if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", bus.err); end
`endif
    endtask

    task automatic test_directed();
        int tv[4][4] = '{'{8, 10, 14, 1000}, '{0, 0, 0, 0}, '{15, 14, 16, 4079}, '{15, 15, 15, 15}};
        logic [3*N-1:0] res;
        int k, bc;
        for (int i = 0; i < 4; i++) begin
            launch(tv[i][0], tv[i][1], tv[i][2]);
            wait_done(0, res, k, bc);
            n_vec++;
            if (res !== (3*N)'(tv[i][3])) begin
                n_err++; $display("FAIL directed_result[%0d] got=%0d exp=%0d", i, res, tv[i][3]);
            end
            n_vec++;
            if (k != LAT) begin n_err++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, k, LAT); end
            n_vec++;
            if (bc != LAT) begin n_err++; $display("FAIL directed_busy_cycles[%0d] got=%0d exp=%0d", i, bc, LAT); end
            n_vec++;
            if (bus.busy !== 1'b0) begin n_err++; $display("FAIL directed_busy_at_done[%0d] got=%b exp=0", i, bus.busy); end
            @(negedge clk);
            n_vec++;
            if (bus.done !== 1'b0) begin n_err++; $display("FAIL directed_done_width[%0d] got=%b exp=0", i, bus.done); end
            n_vec++;
            if (bus.result !== (3*N)'(tv[i][3])) begin
                n_err++; $display("FAIL directed_result_hold[%0d] got=%0d exp=%0d", i, bus.result, tv[i][3]);
            end
        end
    endtask

    task automatic test_random();
        logic [3*N-1:0] res, exp_v;
        int a, b, c, k, bc;
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, M1 - 1);
            b = $urandom_range(0, M1 - 1);
            c = $urandom_range(0, M1);
            exp_q.push_back((3*N)'(ref_x(a, b, c)));
            launch(a, b, c);
            wait_done(0, res, k, bc);
            exp_v = exp_q.pop_front();
            n_vec++;
            if (res !== exp_v) begin
                n_err++; $display("FAIL random_result a=%0d b=%0d c=%0d got=%0d exp=%0d", a, b, c, res, exp_v);
            end
            n_vec++;
            if (k != LAT) begin n_err++; $display("FAIL random_latency got=%0d exp=%0d", k, LAT); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3*N-1:0] res;
        int k, bc;
        launch(8, 10, 14);
        wait_done(0, res, k, bc);
        n_vec++;
        if (res !== 12'd1000) begin n_err++; $display("FAIL b2b_first got=%0d exp=1000", res); end
        // start driven during the done cycle
        launch(1, 1, 1);
        wait_done(0, res, k, bc);
        n_vec++;
        if (res !== 12'd1) begin n_err++; $display("FAIL b2b_second got=%0d exp=1", res); end
        n_vec++;
        if (k != LAT) begin n_err++; $display("FAIL b2b_latency got=%0d exp=%0d", k, LAT); end
    endtask

    task automatic test_ignore_busy();
        logic [3*N-1:0] res;
        int k, bc, extra;
        launch(8, 10, 14);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.residue_a = 4'd1;
        bus.residue_b = 4'd1;
        bus.residue_c = 5'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(3, res, k, bc);
        n_vec++;
        if (res !== 12'd1000) begin n_err++; $display("FAIL ignore_result got=%0d exp=1000", res); end
        n_vec++;
        if (k != LAT) begin n_err++; $display("FAIL ignore_latency got=%0d exp=%0d", k, LAT); end
        n_vec++;
        if (bc != LAT - 3) begin n_err++; $display("FAIL ignore_busy_cycles got=%0d exp=%0d", bc, LAT - 3); end
        extra = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        n_vec++;
        if (extra != 0) begin n_err++; $display("FAIL ignore_no_queue got=%0d exp=0", extra); end
        n_vec++;
        if (bus.result !== 12'd1000) begin n_err++; $display("FAIL ignore_result_hold got=%0d exp=1000", bus.result); end
    endtask

    task automatic test_reset_mid();
        logic [3*N-1:0] res;
        int k, bc;
        launch(8, 10, 14);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        n_vec++;
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b exp=0", bus.done); end
        n_vec++;
        if (bus.result !== '0) begin n_err++; $display("FAIL rstmid_result got=%0d exp=0", bus.result); end
        repeat (LAT + 2) @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL rstmid_stays_idle busy=%b done=%b exp=0,0", bus.busy, bus.done);
        end
        launch(8, 10, 14);
        wait_done(0, res, k, bc);
        n_vec++;
        if (res !== 12'd1000) begin n_err++; $display("FAIL rstmid_restart got=%0d exp=1000", res); end
    endtask

    task automatic test_exhaustive();
        logic [3*N-1:0] res;
        int k, bc, base, shown;
        @(negedge clk);
        #1;
        base = done_total;
        shown = 0;
        for (int x = 0; x < P; x++) begin
            launch(x % M1, x % M2, x % M3);
            wait_done(0, res, k, bc);
            n_vec++;
            if (res !== (3*N)'(x) || k != LAT) begin
                n_err++;
                if (shown < 10) $display("FAIL exhaustive x=%0d got=%0d latency=%0d exp_latency=%0d", x, res, k, LAT);
                shown++;
            end
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (done_total - base != P) begin
            n_err++; $display("FAIL exhaustive_done_count got=%0d exp=%0d", done_total - base, P);
        end
    endtask

`ifdef RNS_RANGE_CHECK_EN
    task automatic test_range_check();
        logic [3*N-1:0] res;
        int k, bc;
        launch(5, 3, 17);
        wait_done(0, res, k, bc);
        n_vec++;
        if (bus.err !== 1'b1) begin n_err++; $display("FAIL range_err17 got=%b exp=1", bus.err); end
        n_vec++;
        if (res !== '0) begin n_err++; $display("FAIL range_result17 got=%0d exp=0", res); end
        n_vec++;
        if (k != LAT) begin n_err++; $display("FAIL range_latency17 got=%0d exp=%0d", k, LAT); end
        @(negedge clk);
        n_vec++;
        if (bus.err !== 1'b0) begin n_err++; $display("FAIL range_err_pulse got=%b exp=0", bus.err); end
        launch(9, 2, 31);
        wait_done(0, res, k, bc);
        n_vec++;
        if (bus.err !== 1'b1 || res !== '0) begin
            n_err++; $display("FAIL range_c31 err=%b result=%0d exp=1,0", bus.err, res);
        end
        launch(15, 14, 16);
        wait_done(0, res, k, bc);
        n_vec++;
        if (bus.err !== 1'b0) begin n_err++; $display("FAIL range_err16 got=%b exp=0", bus.err); end
        n_vec++;
        if (res !== 12'd4079) begin n_err++; $display("FAIL range_result16 got=%0d exp=4079", res); end
    endtask
`else
    task automatic test_out_of_range();
        logic [3*N-1:0] res;
        int k, bc;
        launch(3, 3, 20);
        wait_done(0, res, k, bc);
        n_vec++;
        if (k != LAT) begin n_err++; $display("FAIL oor_latency got=%0d exp=%0d", k, LAT); end
        launch(8, 10, 14);
        wait_done(0, res, k, bc);
        n_vec++;
        if (res !== 12'd1000) begin n_err++; $display("FAIL oor_recovery got=%0d exp=1000", res); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
`ifdef RNS_RANGE_CHECK_EN
        test_range_check();
`else
        test_out_of_range();
`endif
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
